alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mc_iter.sv | 84 ++++++++
 rtl/alu_mc.sv | 157 +++++++++++++++
 tb/tb_alu_mc.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode values and FSM state encoding.
package alu_pkg;

  // Opcode values; compared against the AC_N-bit op port after a width cast.
  localparam int OP_AD = 0;
  localparam int OP_SB = 1;
  localparam int OP_AN = 2;
  localparam int OP_OR = 3;
  localparam int OP_LS = 4;
  localparam int OP_LT = 5;
  localparam int OP_SL = 6;
  localparam int OP_SR = 7;
  localparam int OP_MU = 8;
  localparam int OP_DV = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath for MU (shift-add) and DV (restoring division), one bit per cycle.
// Both share the {hi,lo} shift register, the operand register and the bit counter.
// The divide path exists only when ALU_MC_DIV_EN is defined.
module alu_mc_iter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         div_in,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         last,
  output logic         div_mode,
  output logic [N-1:0] lo_nxt,
  output logic [N-1:0] hi_nxt
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_q, div_d;
  logic [N:0]    add;
`ifdef ALU_MC_DIV_EN
  logic [N:0]    rem_sh, diff;
  logic          q_bit;
`endif

  // One iteration step, plus load/step selection of the next register values.
  always_comb begin
    add    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    hi_nxt = add[N:1];
    lo_nxt = {add[0], lo_q[N-1:1]};
`ifdef ALU_MC_DIV_EN
    rem_sh = {hi_q, lo_q[N-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    q_bit  = (rem_sh >= {1'b0, opnd_q});
    if (div_q) begin
      hi_nxt = q_bit ? diff[N-1:0] : rem_sh[N-1:0];
      lo_nxt = {lo_q[N-2:0], q_bit};
    end
`endif
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    if (load) begin
      // MU keeps the multiplier in lo and adds a; DV shifts the dividend out of lo.
      hi_d   = '0;
      lo_d   = div_in ? a_in : b_in;
      opnd_d = div_in ? b_in : a_in;
      cnt_d  = '0;
      div_d  = div_in;
    end else if (step) begin
      hi_d  = hi_nxt;
      lo_d  = lo_nxt;
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
    end
  end

  assign last     = (cnt_q == CW'(N - 1));
  assign div_mode = div_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: IDLE/BUSY/DONE handshake, single-cycle ops computed here,
// MU/DV delegated to alu_mc_iter. Define ALU_MC_DIV_EN to build the divider.
module alu_mc
  import alu_pkg::*;
#(
  parameter int N    = 8,
  parameter int AC_N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AC_N-1:0] op,
  input  logic [N-1:0]    data_a,
  input  logic [N-1:0]    data_b,
  input  logic            carry_in,
  output logic            ready,
  output logic            valid,
  output logic [N-1:0]    result,
  output logic [N-1:0]    result_hi,
  output logic            zero,
  output logic            carry_out,
  output logic            err
);

  state_e         state_q, state_d;
  logic [N-1:0]   result_q, result_d, hi_q, hi_d;
  logic           carry_q, carry_d, err_q, err_d;

  logic [N-1:0]   sc_res, sc_hi;
  logic           sc_carry, sc_err, sc_multi, sc_div;
  logic [2*N-1:0] shl_w, shr_w;
  logic           accept;

  logic           it_load, it_step, it_last, it_div;
  logic [N-1:0]   it_lo, it_hi;

  assign accept = start && (state_q != ST_BUSY);

  // Shifts run through a 2N-bit window so the bit just past the word is the last one shifted out.
  assign shl_w = {{N{1'b0}}, data_a} << data_b;
  assign shr_w = {data_a, {N{1'b0}}} >> data_b;

  // Single-cycle results and classification of multi-cycle / faulting requests.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    sc_res   = '0;
    sc_hi    = '0;
    sc_carry = 1'b0;
    sc_err   = 1'b0;
    sc_multi = 1'b0;
    sc_div   = 1'b0;
    case (op)
      AC_N'(OP_AD): {sc_carry, sc_res} = {1'b0, data_a} + {1'b0, data_b} + (N+1)'(carry_in);
      AC_N'(OP_SB): {sc_carry, sc_res} = {1'b0, data_a} + {1'b0, ~data_b} + (N+1)'(carry_in);
      AC_N'(OP_AN): sc_res = data_a & data_b;
      AC_N'(OP_OR): sc_res = data_a | data_b;
      AC_N'(OP_LS): sc_res = N'(data_a < data_b);
      AC_N'(OP_LT): sc_res = N'($signed(data_a) < $signed(data_b));
      AC_N'(OP_SL): {sc_carry, sc_res} = shl_w[N:0];
      AC_N'(OP_SR): {sc_res, sc_carry} = shr_w[2*N-1:N-1];
      AC_N'(OP_MU): sc_multi = 1'b1;
`ifdef ALU_MC_DIV_EN
      AC_N'(OP_DV): begin
        if (data_b == '0) begin
          sc_res = '1;
          sc_hi  = data_a;
          sc_err = 1'b1;
        end else begin
          sc_multi = 1'b1;
          sc_div   = 1'b1;
        end
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end

  // FSM next state and output registers; results change only on entry to DONE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    err_d    = err_q;
    it_load  = 1'b0;
    it_step  = 1'b0;
    case (state_q)
      ST_BUSY: begin
        it_step = 1'b1;
        if (it_last) begin
          state_d  = ST_DONE;
          result_d = it_lo;
          hi_d     = it_hi;
          carry_d  = !it_div && (|it_hi);
          err_d    = 1'b0;
        end
      end
      default: begin
        if (accept) begin
          if (sc_multi) begin
            state_d = ST_BUSY;
            it_load = 1'b1;
          end else begin
            state_d  = ST_DONE;
            result_d = sc_res;
            hi_d     = sc_hi;
            carry_d  = sc_carry;
            err_d    = sc_err;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  // NOTE: non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  alu_mc_iter #(.N(N)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (it_load),
    .step     (it_step),
    .div_in   (sc_div),
    .a_in     (data_a),
    .b_in     (data_b),
    .last     (it_last),
    .div_mode (it_div),
    .lo_nxt   (it_lo),
    .hi_nxt   (it_hi)
  );

  assign ready     = (state_q != ST_BUSY);
  assign valid     = (state_q == ST_DONE);
  assign result    = result_q;
  assign result_hi = hi_q;
  assign zero      = ~|result_q;
  assign carry_out = carry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (N=8, AC_N=4).
module tb_alu_mc;
  import alu_pkg::*;

  logic       clk, rst_n, start, carry_in;
  logic [3:0] op;
  logic [7:0] data_a, data_b;
  logic       ready, valid, zero, carry_out, err;
  logic [7:0] result, result_hi;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mc #(.N(8), .AC_N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .data_a    (data_a),
    .data_b    (data_b),
    .carry_in  (carry_in),
    .ready     (ready),
    .valid     (valid),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .carry_out (carry_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full output vector check.
  task automatic check_out(input string tag, input logic v, input logic [7:0] r, input logic [7:0] h,
                           input logic c, input logic e);
    check({tag, ".valid"}, valid, v);
    check({tag, ".result"}, result, r);
    check({tag, ".result_hi"}, result_hi, h);
    check({tag, ".zero"}, zero, (r == 8'h00));
    check({tag, ".carry"}, carry_out, c);
    check({tag, ".err"}, err, e);
  endtask

  // Present one request at a negedge; returns just after the accepting edge with start low.
  task automatic issue(input int o, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    start = 1'b1; op = 4'(o); data_a = a; data_b = b; carry_in = c;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; data_a = '0; data_b = '0; carry_in = 1'b0;
    #3;
    check("rst.ready", ready, 1'b1);
    check_out("rst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // AD with carry-in, latency 1
    issue(OP_AD, 8'hF0, 8'h20, 1'b1);
    @(negedge clk);
    check_out("ad", 1'b1, 8'h11, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("ad.pulse_end", valid, 1'b0);
    check("ad.hold", result, 8'h11);

    issue(OP_SB, 8'h05, 8'h05, 1'b1);
    @(negedge clk);
    check_out("sb", 1'b1, 8'h00, 8'h00, 1'b1, 1'b0);

    issue(OP_LT, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    check_out("lt", 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);

    issue(OP_LS, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    check_out("ls", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

    // MU 0xFF*0xFF = 0xFE01; an AD request during BUSY must be dropped
    issue(OP_MU, 8'hFF, 8'hFF, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("mu.busy%0d.ready", k), ready, 1'b0);
      check($sformatf("mu.busy%0d.valid", k), valid, 1'b0);
      if (k == 3) begin
        start = 1'b1; op = 4'(OP_AD); data_a = 8'h01; data_b = 8'h01; carry_in = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check_out("mu", 1'b1, 8'h01, 8'hFE, 1'b1, 1'b0);
    @(negedge clk);
    check("mu.no_queue", valid, 1'b0);
    check("mu.hold", result, 8'h01);

`ifdef ALU_MC_DIV_EN
    issue(OP_DV, 8'd200, 8'd7, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("dv.busy%0d.valid", k), valid, 1'b0);
    end
    @(negedge clk);
    check_out("dv", 1'b1, 8'd28, 8'd4, 1'b0, 1'b0);
    issue(OP_DV, 8'h05, 8'h00, 1'b0);
    @(negedge clk);
    check_out("dv0", 1'b1, 8'hFF, 8'h05, 1'b0, 1'b1);
`else
    issue(OP_DV, 8'd200, 8'd7, 1'b0);
    @(negedge clk);
    check_out("dv_off", 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
`endif

    // Undefined opcode
    issue(15, 8'h12, 8'h34, 1'b1);
    @(negedge clk);
    check_out("undef", 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);

    // Reset at BUSY cycle 4 of MU aborts with no valid pulse
    issue(OP_MU, 8'h0F, 8'h03, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstbusy.ready", ready, 1'b1);
    check_out("rstbusy", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("rstbusy.idle%0d", k), valid, 1'b0);
    end
    issue(OP_AN, 8'hCC, 8'hAA, 1'b0);
    @(negedge clk);
    check_out("an", 1'b1, 8'h88, 8'h00, 1'b0, 1'b0);

    // Back-to-back AD then OR
    @(negedge clk);
    start = 1'b1; op = 4'(OP_AD); data_a = 8'h12; data_b = 8'h34; carry_in = 1'b0;
    @(negedge clk);
    check_out("b2b.ad", 1'b1, 8'h46, 8'h00, 1'b0, 1'b0);
    op = 4'(OP_OR); data_a = 8'h0F; data_b = 8'hF0;
    @(negedge clk);
    start = 1'b0;
    check_out("b2b.or", 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Shifts
    issue(OP_SL, 8'h81, 8'd1, 1'b0);
    @(negedge clk);
    check_out("sl1", 1'b1, 8'h02, 8'h00, 1'b1, 1'b0);
    issue(OP_SR, 8'h81, 8'd1, 1'b0);
    @(negedge clk);
    check_out("sr1", 1'b1, 8'h40, 8'h00, 1'b1, 1'b0);
    issue(OP_SR, 8'h81, 8'd9, 1'b0);
    @(negedge clk);
    check_out("sr9", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    issue(OP_SL, 8'h81, 8'd0, 1'b0);
    @(negedge clk);
    check_out("sl0", 1'b1, 8'h81, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
